// File: rtl/tape_recorder_pkg.sv
// Shared types and default timing for the Oric tape-save path.
package oric_tape_pkg;
  localparam int CNT_W       = 16;
  localparam int DEF_MIN_PER = 4800;   // 200 us at 24 MHz
  localparam int DEF_THRESH  = 12500;  // 1/0 decision point, ~520 us
  localparam int DEF_TIMEOUT = 48000;  // 2 ms without an edge abandons the frame

  typedef enum logic [2:0] {IDLE, HUNT, DATA, PARITY, STOP} state_e;
endpackage

// File: rtl/tape_recorder_if.sv
// Tape cache write bus plus recorder status, driven by the recorder.
interface tape_recorder_if #(parameter int ADDR_W = 16);
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_en;
  logic [ADDR_W-1:0] tape_end;
  logic              recorded;
  logic              full;
  logic [7:0]        parity_err_cnt;
  logic              active;

  modport master (output wr_addr, wr_data, wr_en, tape_end, recorded, full,
                         parity_err_cnt, active);
  modport slave  (input  wr_addr, wr_data, wr_en, tape_end, recorded, full,
                         parity_err_cnt, active);
endinterface

// File: rtl/tape_recorder_pulse_decoder.sv
// Turns the raw K7_TAPEOUT square wave into decoded bits by timing rising edges.
module tape_pulse_decoder
  import oric_tape_pkg::*;
#(
  parameter int MIN_PER = DEF_MIN_PER,
  parameter int THRESH  = DEF_THRESH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic tape_in,
  output logic bit_valid,
  output logic bit_val,
  output logic timeout_pulse
);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PER);
  localparam logic [CNT_W-1:0] THR_C = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);

  logic [2:0]       sync_q;
  logic             edge_q;
  logic             armed_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             tmo_hit;
  logic             accept;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign tmo_hit = armed_q && (cnt_q >= TMO_C);
  // An edge is taken when it arms a fresh measurement or closes a long-enough period
  assign accept  = edge_q && (!armed_q || (cnt_q >= MIN_C)) && !tmo_hit;

  assign bit_valid     = accept && armed_q && !clear;
  assign bit_val       = cnt_q < THR_C;
  assign timeout_pulse = tmo_hit && !clear;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[1:0], tape_in};
      edge_q <= sync_q[1] & ~sync_q[2];
      if (clear) begin
        armed_q <= 1'b0;
        cnt_q   <= '0;
      end else if (tmo_hit) begin
        armed_q <= 1'b0;
        cnt_q   <= cnt_inc;
      end else if (accept) begin
        armed_q <= 1'b1;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_inc;
      end
    end
  end
endmodule

// File: rtl/tape_recorder.sv
// Deframes tape bits into bytes and appends them to the tape cache RAM.
module tape_recorder
  import oric_tape_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int MIN_PER = DEF_MIN_PER,
  parameter int THRESH  = DEF_THRESH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  input  logic            rewind,
  input  logic            tape_out,
  tape_recorder_if.master wr
);
  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        sh_q, sh_d;
  logic              wr_go, perr_inc;
  logic [ADDR_W-1:0] ptr_q, end_q, waddr_q;
  logic [7:0]        wdata_q, perr_q;
  logic              rec_q, full_q, wr_en_q;
  logic              bit_valid, bit_val, tmo;

  tape_pulse_decoder #(
    .MIN_PER(MIN_PER),
    .THRESH (THRESH),
    .TIMEOUT(TIMEOUT)
  ) u_dec (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (~en | rewind),
    .tape_in      (tape_out),
    .bit_valid    (bit_valid),
    .bit_val      (bit_val),
    .timeout_pulse(tmo)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    wr_go    = 1'b0;
    perr_inc = 1'b0;
    case (state_q)
      IDLE: state_d = HUNT;
      HUNT: if (bit_valid && !bit_val) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA: if (bit_valid) begin
        sh_d  = {bit_val, sh_q[7:1]};
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (bit_valid) begin
        wr_go    = 1'b1;
        perr_inc = (bit_val != ~^sh_q);
        state_d  = STOP;
      end
      STOP: if (bit_valid) begin
        // a 0 here is the start bit of a back-to-back byte
        state_d = bit_val ? HUNT : DATA;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    if (tmo && (state_q inside {DATA, PARITY, STOP})) state_d = HUNT;
    if (rewind) begin
      state_d  = HUNT;
      wr_go    = 1'b0;
      perr_inc = 1'b0;
    end
    if (!en) begin
      state_d  = IDLE;
      wr_go    = 1'b0;
      perr_inc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      end_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      perr_q  <= '0;
      rec_q   <= 1'b0;
      full_q  <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      wr_en_q <= wr_go && !full_q;
      if (rewind) begin
        ptr_q  <= '0;
        end_q  <= '0;
        perr_q <= '0;
        rec_q  <= 1'b0;
        full_q <= 1'b0;
      end else begin
        if (perr_inc && (perr_q != 8'hFF)) perr_q <= perr_q + 8'd1;
        if (wr_go && !full_q) begin
          waddr_q <= ptr_q;
          wdata_q <= sh_q;
          end_q   <= ptr_q;
          rec_q   <= 1'b1;
          // the last location is written once, then the pointer parks there
          if (&ptr_q) full_q <= 1'b1;
          else        ptr_q  <= ptr_q + 1'b1;
        end
      end
    end
  end

  assign wr.wr_en          = wr_en_q & ~rewind;
  assign wr.wr_addr        = waddr_q;
  assign wr.wr_data        = wdata_q;
  assign wr.tape_end       = end_q;
  assign wr.recorded       = rec_q;
  assign wr.full           = full_q;
  assign wr.parity_err_cnt = perr_q;
  assign wr.active         = (state_q != IDLE) && (state_q != HUNT);
endmodule

// File: tb/tb_tape_recorder.sv
// Randomised tape-frame stimulus checked against a byte-level model of the recorder.
module tb_tape_recorder;
  localparam int AW   = 4;
  localparam int MINP = 20;
  localparam int THR  = 50;
  localparam int TMO  = 200;
  localparam int P1   = 35;
  localparam int P0   = 65;

  typedef bit bits_t[$];
  typedef struct {int addr; int data;} wr_t;

  logic clk = 1'b0, reset_n = 1'b0, en = 1'b0, rewind = 1'b0, tape_out = 1'b0;
  int errs = 0, checks = 0;

  wr_t exp_q[$];
  int  m_ptr, m_end, m_perr;
  bit  m_rec, m_full;

  tape_recorder_if #(.ADDR_W(AW)) wr ();

  tape_recorder #(.ADDR_W(AW), .MIN_PER(MINP), .THRESH(THR), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .rewind  (rewind),
    .tape_out(tape_out),
    .wr      (wr.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    exp_q.delete();
    m_ptr = 0; m_end = 0; m_perr = 0; m_rec = 0; m_full = 0;
  endfunction

  function automatic void model_byte(input int d, input bit bad);
    if (bad && m_perr < 255) m_perr++;
    if (!m_full) begin
      exp_q.push_back('{addr: m_ptr, data: d});
      m_end = m_ptr;
      m_rec = 1;
      if (m_ptr == (1 << AW) - 1) m_full = 1;
      else m_ptr++;
    end
  endfunction

  function automatic bits_t mk_frame(input int d, input bit bad, input int nlead, input int ntrail);
    bits_t q;
    logic [7:0] db;
    db = d[7:0];
    for (int i = 0; i < nlead; i++) q.push_back(1'b1);
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(db[i]);
    q.push_back(~(^db) ^ bad);
    for (int i = 0; i < ntrail; i++) q.push_back(1'b1);
    return q;
  endfunction

  always @(negedge clk) begin
    if (reset_n && wr.wr_en === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_wr_addr", wr.wr_addr, 999);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", wr.wr_addr, e.addr);
        chk("wr_data", wr.wr_data, e.data);
        chk("tape_end_at_wr", wr.tape_end, e.addr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ev: 0 none, 1 rewind pulse at edge ev_edge, 2 en dropped at edge ev_edge
  task automatic send_bits(input bits_t bits, input bit glitch, input int ev, input int ev_edge);
    int n, per;
    n = bits.size();
    for (int e = 0; e <= n; e++) begin
      if (e < n) per = (bits[e] ? P1 : P0) + int'($urandom_range(0, 8)) - 4;
      else       per = P1;
      for (int c = 0; c < per; c++) begin
        if (e == 5 && c == 0) chk("active_mid_frame", wr.active, 1);
        tape_out = (c < per / 2) && !(glitch && e > 0 && c >= 3 && c < 6);
        rewind   = (ev == 1) && (e == ev_edge) && (c < 8);
        en       = !((ev == 2) && (e == ev_edge) && (c < 10));
        tick();
      end
    end
    tape_out = 1'b0;
    rewind   = 1'b0;
    en       = 1'b1;
    repeat (TMO + 60) tick();
  endtask

  task automatic status(input string tag);
    chk({tag, "_pending"}, exp_q.size(), 0);
    chk({tag, "_recorded"}, wr.recorded, m_rec);
    chk({tag, "_full"}, wr.full, m_full);
    chk({tag, "_perr"}, wr.parity_err_cnt, m_perr);
    chk({tag, "_tape_end"}, wr.tape_end, m_end);
    chk({tag, "_active"}, wr.active, 0);
  endtask

  task automatic do_rewind();
    rewind = 1'b1;
    repeat (2) tick();
    rewind = 1'b0;
    model_clear();
    repeat (2) tick();
    status("rewind");
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_clear();
    repeat (3) tick();
    chk("rst_wr_en", wr.wr_en, 0);
    chk("rst_wr_addr", wr.wr_addr, 0);
    chk("rst_wr_data", wr.wr_data, 0);
    chk("rst_tape_end", wr.tape_end, 0);
    chk("rst_recorded", wr.recorded, 0);
    chk("rst_full", wr.full, 0);
    chk("rst_perr", wr.parity_err_cnt, 0);
    chk("rst_active", wr.active, 0);
    reset_n = 1'b1;
    en = 1'b1;
    repeat (5) tick();

    model_byte(8'h16, 0);
    send_bits(mk_frame(8'h16, 0, 1, 4), 0, 0, 0);
    status("byte16");

    do_rewind();
    model_byte(8'h24, 1);
    send_bits(mk_frame(8'h24, 1, 0, 2), 0, 0, 0);
    status("bad_parity");

    do_rewind();
    model_byte(8'h16, 0);
    send_bits(mk_frame(8'h16, 0, 2, 2), 1, 0, 0);
    status("glitch");

    do_rewind();
    begin
      bits_t part;
      part = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      send_bits(part, 0, 0, 0);
    end
    status("partial");
    model_byte(8'h24, 0);
    send_bits(mk_frame(8'h24, 0, 1, 2), 0, 0, 0);
    status("after_partial");

    do_rewind();
    model_byte(8'h5A, 1);
    send_bits(mk_frame(8'h5A, 1, 1, 2), 0, 0, 0);
    status("pre_rewind");
    model_clear();
    send_bits(mk_frame(8'h33, 0, 1, 2), 0, 1, 11);
    status("rewind_on_write");
    model_byte(8'hC3, 0);
    send_bits(mk_frame(8'hC3, 0, 0, 1), 0, 0, 0);
    status("after_rewind");

    do_rewind();
    model_byte(8'h81, 0);
    send_bits(mk_frame(8'h81, 0, 1, 2), 0, 0, 0);
    send_bits(mk_frame(8'h7E, 0, 1, 3), 0, 2, 6);
    status("en_drop");
    model_byte(8'h42, 0);
    send_bits(mk_frame(8'h42, 0, 1, 2), 0, 0, 0);
    status("append");

    do_rewind();
    for (int i = 0; i < 20; i++) begin
      int d;
      bit bad, g;
      d   = int'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0);
      g   = $urandom_range(0, 1) != 0;
      model_byte(d, bad);
      send_bits(mk_frame(d, bad, int'($urandom_range(0, 2)), int'($urandom_range(1, 3))), g, 0, 0);
      status("random");
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
